// File: rtl/riscv_arb_pkg.sv
// Shared types and defaults for the main-memory arbiter between the icache refill
// and dcache miss/write-back engines; the cache tops reuse the width defaults.
package riscv_arb_pkg;

   localparam int ARB_DATA_WIDTH = 128;
   localparam int ARB_S_ADDR     = 23;
   localparam int ARB_STARVE_MAX = 4;
   localparam int ARB_CTR_W      = 4;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_GNT_I = 2'b01;
   localparam logic [1:0] ST_GNT_D = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      GNT_I = ST_GNT_I,
      GNT_D = ST_GNT_D,
      DONE  = ST_DONE
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_I    = 2'b01,
      OWN_D    = 2'b10
   } arb_owner_e;

   function automatic arb_owner_e owner_of(input arb_state_e s);
      arb_owner_e o;
      case (s)
         GNT_I:   o = OWN_I;
         GNT_D:   o = OWN_D;
         default: o = OWN_NONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/riscv_mem_arb_starve_ctr.sv
// Counts back-to-back dcache grants that overtook a waiting icache refill and
// flags when the icache must win the next tie.
module riscv_mem_arb_starve_ctr
   import riscv_arb_pkg::*;
#(
   parameter int STARVE_MAX = ARB_STARVE_MAX
) (
   input  logic clk,
   input  logic rst_n,
   input  logic grant_d,
   input  logic grant_i,
   input  logic icache_pending,
   output logic starve
);

   localparam logic [ARB_CTR_W-1:0] MAX_CNT = ARB_CTR_W'(STARVE_MAX);

   logic [ARB_CTR_W-1:0] count;

   // Only dcache grants that actually made the icache wait count as starvation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (grant_i) begin
         count <= '0;
      end else if (grant_d) begin
         if (!icache_pending) begin
            count <= '0;
         end else if (count != MAX_CNT) begin
            count <= count + 1'b1;
         end
      end
   end

   assign starve = (count == MAX_CNT);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port main-memory arbiter: dcache-first fixed priority with bounded icache
// starvation, registered memory command, ready/data routed only to the owner.
module riscv_mem_arbiter
   import riscv_arb_pkg::*;
#(
   parameter int DATA_WIDTH = ARB_DATA_WIDTH,
   parameter int S_ADDR     = ARB_S_ADDR,
   parameter int STARVE_MAX = ARB_STARVE_MAX
) (
   input  logic                  i_riscv_arb_clk,
   input  logic                  i_riscv_arb_rst,
   input  logic                  i_riscv_arb_icache_rden,
   input  logic [S_ADDR-1:0]     i_riscv_arb_icache_addr,
   output logic                  o_riscv_arb_icache_ready,
   output logic [DATA_WIDTH-1:0] o_riscv_arb_icache_rdata,
   input  logic                  i_riscv_arb_dcache_rden,
   input  logic                  i_riscv_arb_dcache_wren,
   input  logic [S_ADDR-1:0]     i_riscv_arb_dcache_addr,
   input  logic [DATA_WIDTH-1:0] i_riscv_arb_dcache_wdata,
   output logic                  o_riscv_arb_dcache_ready,
   output logic [DATA_WIDTH-1:0] o_riscv_arb_dcache_rdata,
   output logic                  o_riscv_arb_mem_rden,
   output logic                  o_riscv_arb_mem_wren,
   output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
   output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_wdata,
   input  logic                  i_riscv_arb_mem_ready,
   input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_rdata,
   output logic                  o_riscv_arb_busy
);

   arb_state_e state;
   arb_owner_e owner;
   logic       i_req;
   logic       d_req;
   logic       grant_i;
   logic       grant_d;
   logic       starve;

   assign i_req   = i_riscv_arb_icache_rden;
   assign d_req   = i_riscv_arb_dcache_rden | i_riscv_arb_dcache_wren;
   assign grant_d = (state == IDLE) && d_req && !(i_req && starve);
   assign grant_i = (state == IDLE) && i_req && !grant_d;

   riscv_mem_arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk            (i_riscv_arb_clk),
      .rst_n          (i_riscv_arb_rst),
      .grant_d        (grant_d),
      .grant_i        (grant_i),
      .icache_pending (i_req),
      .starve         (starve)
   );

   // Command is captured once on the grant edge and held until memory answers.
   always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
      if (!i_riscv_arb_rst) begin
         state                 <= IDLE;
         o_riscv_arb_mem_rden  <= 1'b0;
         o_riscv_arb_mem_wren  <= 1'b0;
         o_riscv_arb_mem_addr  <= '0;
         o_riscv_arb_mem_wdata <= '0;
         o_riscv_arb_busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state                <= GNT_D;
                  o_riscv_arb_busy     <= 1'b1;
                  o_riscv_arb_mem_addr <= i_riscv_arb_dcache_addr;
                  if (i_riscv_arb_dcache_wren) begin
                     o_riscv_arb_mem_wren  <= 1'b1;
                     o_riscv_arb_mem_wdata <= i_riscv_arb_dcache_wdata;
                  end else begin
                     o_riscv_arb_mem_rden <= 1'b1;
                  end
               end else if (grant_i) begin
                  state                <= GNT_I;
                  o_riscv_arb_busy     <= 1'b1;
                  o_riscv_arb_mem_addr <= i_riscv_arb_icache_addr;
                  o_riscv_arb_mem_rden <= 1'b1;
               end
            end
            GNT_I, GNT_D: begin
               if (i_riscv_arb_mem_ready) begin
                  state                <= DONE;
                  o_riscv_arb_mem_rden <= 1'b0;
                  o_riscv_arb_mem_wren <= 1'b0;
               end
            end
            default: begin
               state            <= IDLE;
               o_riscv_arb_busy <= 1'b0;
            end
         endcase
      end
   end

   assign owner = owner_of(state);

   // Ready is forwarded combinationally so the icache can write its array that cycle.
   always_comb begin
      o_riscv_arb_icache_ready = 1'b0;
      o_riscv_arb_icache_rdata = '0;
      o_riscv_arb_dcache_ready = 1'b0;
      o_riscv_arb_dcache_rdata = '0;
      if (i_riscv_arb_mem_ready) begin
         if (owner == OWN_I) begin
            o_riscv_arb_icache_ready = 1'b1;
            o_riscv_arb_icache_rdata = i_riscv_arb_mem_rdata;
         end else if (owner == OWN_D) begin
            o_riscv_arb_dcache_ready = 1'b1;
            o_riscv_arb_dcache_rdata = i_riscv_arb_mem_rdata;
         end
      end
   end

endmodule
